regfile_wb_arbiter: RTL and testbench

//  Shares the register file's WRITE_PORTS write ports among NUM_REQ writeback requesters (FUs, load unit, commit).

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle plus the register-file write-port bundle.
// The master side is the group of writeback requesters. The slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int SIZE        = 32,
    parameter int REG_NUM     = 64,
    parameter int NUM_REQ     = 4,
    parameter int WRITE_PORTS = 3
);
    localparam int RW = $clog2(REG_NUM);
    localparam int CW = $clog2(WRITE_PORTS + 1);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][RW-1:0]        req_reg;
    logic [NUM_REQ-1:0][SIZE-1:0]      req_data;
    logic [NUM_REQ-1:0]                req_ready;
    logic [WRITE_PORTS-1:0]            RegWrite;
    logic [WRITE_PORTS-1:0][RW-1:0]    write_reg;
    logic [WRITE_PORTS-1:0][SIZE-1:0]  write_data;
    logic [CW-1:0]                     grant_cnt;

    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, RegWrite, write_reg, write_data, grant_cnt
    );

    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, RegWrite, write_reg, write_data, grant_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter. It shares WRITE_PORTS register-file write ports
// among NUM_REQ requesters and never grants two writes to the same register.
module regfile_wb_arbiter #(
    parameter int SIZE        = 32,
    parameter int REG_NUM     = 64,
    parameter int NUM_REQ     = 4,
    parameter int WRITE_PORTS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int RW = $clog2(REG_NUM);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WRITE_PORTS + 1);
    localparam logic [CW-1:0] WP_C  = CW'(WRITE_PORTS);
    localparam logic [PW:0]   NR_C  = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST  = PW'(NUM_REQ - 1);

    logic [PW-1:0]                    rr_ptr, nxt_ptr;
    logic [NUM_REQ-1:0]               grant;
    logic [CW-1:0]                    used;
    logic [WRITE_PORTS-1:0]           nxt_we;
    logic [WRITE_PORTS-1:0][RW-1:0]   nxt_reg;
    logic [WRITE_PORTS-1:0][SIZE-1:0] nxt_data;

    logic [WRITE_PORTS-1:0]           we_q;
    logic [WRITE_PORTS-1:0][RW-1:0]   reg_q;
    logic [WRITE_PORTS-1:0][SIZE-1:0] data_q;
    logic [CW-1:0]                    cnt_q;

    // Scan requesters from rr_ptr. Each winner takes the next free port. A
    // request that targets a register already granted in this scan is skipped.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic          conflict;
        grant    = '0;
        used     = '0;
        nxt_we   = '0;
        nxt_reg  = '0;
        nxt_data = '0;
        nxt_ptr  = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= NR_C)
                sum = sum - NR_C;
            idx = sum[PW-1:0];
            conflict = 1'b0;
            for (int j = 0; j < NUM_REQ; j++)
                if (grant[j] && (bus.req_reg[j] == bus.req_reg[idx]))
                    conflict = 1'b1;
            if (rst_n && bus.req_valid[idx] && (used < WP_C) && !conflict) begin
                grant[idx] = 1'b1;
                for (int p = 0; p < WRITE_PORTS; p++)
                    if (used == CW'(p)) begin
                        nxt_we[p]   = 1'b1;
                        nxt_reg[p]  = bus.req_reg[idx];
                        nxt_data[p] = bus.req_data[idx];
                    end
                used    = used + 1'b1;
                nxt_ptr = (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Register the port bundle. Idle ports keep their old index and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            we_q   <= '0;
            reg_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            rr_ptr <= nxt_ptr;
            we_q   <= nxt_we;
            cnt_q  <= used;
            for (int p = 0; p < WRITE_PORTS; p++)
                if (nxt_we[p]) begin
                    reg_q[p]  <= nxt_reg[p];
                    data_q[p] <= nxt_data[p];
                end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.RegWrite   = we_q;
    assign bus.write_reg  = reg_q;
    assign bus.write_data = data_q;
    assign bus.grant_cnt  = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed check of regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int SIZE = 32, REG_NUM = 64, NUM_REQ = 4, WRITE_PORTS = 3;
    localparam int RW = $clog2(REG_NUM);
    localparam int CW = $clog2(WRITE_PORTS + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.SIZE(SIZE), .REG_NUM(REG_NUM), .NUM_REQ(NUM_REQ),
                            .WRITE_PORTS(WRITE_PORTS)) bus ();

    regfile_wb_arbiter #(.SIZE(SIZE), .REG_NUM(REG_NUM), .NUM_REQ(NUM_REQ),
                         .WRITE_PORTS(WRITE_PORTS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0, miscompares = 0;

    // Requester-side state and the reference model.
    logic [NUM_REQ-1:0]  v = '0;
    logic [RW-1:0]       r [NUM_REQ];
    logic [SIZE-1:0]     d [NUM_REQ];
    int                  ptr = 0;
    logic [NUM_REQ-1:0]  last_gr = '0;
    logic [WRITE_PORTS-1:0] exp_we = '0;
    logic [RW-1:0]       exp_reg [WRITE_PORTS];
    logic [SIZE-1:0]     exp_data [WRITE_PORTS];
    int                  exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = v[i];
            bus.req_reg[i]   = r[i];
            bus.req_data[i]  = d[i];
        end
    endtask

    // Drive the current requests, predict the grants, and check req_ready.
    task automatic arbitrate();
        int order[$];
        logic [RW-1:0] taken[$];
        logic [NUM_REQ-1:0] gr;
        bit dup;
        drive();
        #1;
        gr = '0;
        exp_we = '0;
        for (int k = 0; k < NUM_REQ; k++) order.push_back((ptr + k) % NUM_REQ);
        foreach (order[n]) begin
            int i;
            i = order[n];
            dup = 1'b0;
            foreach (taken[t]) if (taken[t] == r[i]) dup = 1'b1;
            if (v[i] && taken.size() < WRITE_PORTS && !dup) begin
                gr[i] = 1'b1;
                exp_we[taken.size()]   = 1'b1;
                exp_reg[taken.size()]  = r[i];
                exp_data[taken.size()] = d[i];
                taken.push_back(r[i]);
                ptr = (i + 1) % NUM_REQ;
            end
        end
        exp_cnt = taken.size();
        chk("req_ready", 64'(bus.req_ready), 64'(gr));
        last_gr = gr;
    endtask

    // Advance to the next negedge, check the registered bundle, and retire granted requests.
    task automatic next_cycle();
        @(negedge clk);
        chk("RegWrite", 64'(bus.RegWrite), 64'(exp_we));
        chk("grant_cnt", 64'(bus.grant_cnt), 64'(exp_cnt));
        for (int p = 0; p < WRITE_PORTS; p++)
            if (exp_we[p]) begin
                chk("write_reg", 64'(bus.write_reg[p]), 64'(exp_reg[p]));
                chk("write_data", 64'(bus.write_data[p]), 64'(exp_data[p]));
            end
        v = v & ~last_gr;
        last_gr = '0;
    endtask

    // Pull reset between clock edges. Leave the bench at a negedge with reset released.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_RegWrite", 64'(bus.RegWrite), 64'(0));
        chk("rst_grant_cnt", 64'(bus.grant_cnt), 64'(0));
        chk("rst_ready", 64'(bus.req_ready), 64'(0));
        v = '0; ptr = 0; last_gr = '0; exp_we = '0; exp_cnt = 0;
        drive();
        @(posedge clk);
        #1 chk("rst_hold_RegWrite", 64'(bus.RegWrite), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int rg, input logic [SIZE-1:0] dt);
        v[i] = 1'b1; r[i] = RW'(rg); d[i] = dt;
    endtask

    // Bring all requesters valid on regs 1..4, then hold requester 3 and reissue
    // the others. The rotation must be 012, 301, 230, 123.
    task automatic case1_2();
        logic [NUM_REQ-1:0] ready_tbl [4];
        ready_tbl[0] = 4'b0111; ready_tbl[1] = 4'b1011;
        ready_tbl[2] = 4'b1101; ready_tbl[3] = 4'b1110;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i + 1, 32'h100 + 32'(i));
        for (int c = 0; c < 4; c++) begin
            arbitrate();
            chk("rr_ready", 64'(bus.req_ready), 64'(ready_tbl[c]));
            next_cycle();
            if (c == 0) begin
                chk("c1_write_reg", 64'(bus.write_reg), 64'({6'd3, 6'd2, 6'd1}));
                chk("c1_RegWrite", 64'(bus.RegWrite), 64'(3'b111));
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (!v[i]) set_req(i, i + 1, 32'h200 + 32'(c * 4 + i));
        end
        v = '0;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin r[i] = '0; d[i] = '0; end
        for (int p = 0; p < WRITE_PORTS; p++) begin exp_reg[p] = '0; exp_data[p] = '0; end
        drive();
        do_reset();

        case1_2();
        arbitrate(); next_cycle();

        // Requesters 0 and 1 both target reg 5, so requester 1 must wait a cycle.
        do_reset();
        set_req(0, 5, 32'hA0A0_0000); set_req(1, 5, 32'hB1B1_1111); set_req(2, 7, 32'hC2C2_2222);
        arbitrate();
        chk("c3_ready", 64'(bus.req_ready), 64'(4'b0101));
        next_cycle();
        chk("c3_p0", 64'({bus.write_reg[0], bus.write_data[0]}), {26'd0, 6'd5, 32'hA0A0_0000});
        chk("c3_p1_reg", 64'(bus.write_reg[1]), 64'(7));
        arbitrate();
        chk("c3_late_ready", 64'(bus.req_ready), 64'(4'b0010));
        next_cycle();

        // A single requester uses port 0 only.
        set_req(2, 9, 32'hDEAD_BEEF);
        arbitrate();
        chk("c4_ready", 64'(bus.req_ready), 64'(4'b0100));
        next_cycle();
        chk("c4_RegWrite", 64'(bus.RegWrite), 64'(3'b001));
        chk("c4_data", 64'(bus.write_data[0]), 64'(32'hDEAD_BEEF));

        // Idle cycles. The pointer must not move, and the model confirms this on the next grant.
        for (int c = 0; c < 3; c++) begin arbitrate(); next_cycle(); end
        set_req(0, 11, 32'h1); set_req(3, 12, 32'h2);
        arbitrate();
        chk("c5_ready", 64'(bus.req_ready), 64'(4'b1001));
        next_cycle();

        // Random traffic on a small register range so that conflicts are common.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!v[i] && ($urandom_range(0, 99) < 70))
                    set_req(i, int'($urandom_range(0, 5)), $urandom);
            arbitrate();
            next_cycle();
        end

        // Pull reset in the middle of a burst. Case 1 must then repeat exactly.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i + 20, $urandom);
        arbitrate();
        do_reset();
        case1_2();
        arbitrate(); next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
